// File: rtl/multu_hilo_pkg.sv
// Shared control codes from the ALU control stage and the multiplier FSM states.
package multu_hilo_pkg;

  localparam logic [5:0] AND_CODE   = 6'b100100;
  localparam logic [5:0] OR_CODE    = 6'b100101;
  localparam logic [5:0] ADD_CODE   = 6'b100000;
  localparam logic [5:0] SUB_CODE   = 6'b100010;
  localparam logic [5:0] SLT_CODE   = 6'b101010;
  localparam logic [5:0] SLL_CODE   = 6'b000000;
  localparam logic [5:0] MULTU_CODE = 6'b011001;
  localparam logic [5:0] HILO_CODE  = 6'b111111;
  localparam logic [5:0] MFHI_CODE  = 6'b010000;
  localparam logic [5:0] MFLO_CODE  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_HILO
  } state_t;

endpackage

// File: rtl/multu_hilo_if.sv
// Control/data bundle between the ALU control stage (master) and multu_hilo (slave).
interface multu_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dataOut;
  logic             busy;

  modport master (
    output Signal, dataA, dataB,
    input  hi, lo, dataOut, busy
  );

  modport slave (
    input  Signal, dataA, dataB,
    output hi, lo, dataOut, busy
  );
endinterface

// File: rtl/multu_hilo_step.sv
// One shift-add iteration: conditionally add mcand into the upper half, keep the
// carry, then shift the whole product right by one.
module multu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] p_next
);
  logic [WIDTH:0]   t;
  logic [2*WIDTH:0] wide;

  always_comb begin
    t = p[0] ? ({1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
             : {1'b0, p[2*WIDTH-1:WIDTH]};
    wide   = {t, p[WIDTH-1:0]};
    p_next = wide[2*WIDTH:1];
  end
endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier with HI/LO result register and MFHI/MFLO read port.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  MULTU_CODE = multu_hilo_pkg::MULTU_CODE,
  parameter logic [5:0]  HILO_CODE  = multu_hilo_pkg::HILO_CODE,
  parameter logic [5:0]  MFHI_CODE  = multu_hilo_pkg::MFHI_CODE,
  parameter logic [5:0]  MFLO_CODE  = multu_hilo_pkg::MFLO_CODE
) (
  input  logic         clk,
  input  logic         reset,
  multu_hilo_if.slave  bus
);
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   product, product_n;
  logic [WIDTH-1:0]     mcand, mcand_n;
  logic [5:0]           count, count_n;
  logic [WIDTH-1:0]     hi_q, hi_n, lo_q, lo_n;

  logic [2*WIDTH-1:0]   step_in, step_out;
  logic [WIDTH-1:0]     step_mcand;

  // The first iteration happens on the start edge itself, straight from the operand inputs.
  assign step_in    = (state == IDLE) ? {{WIDTH{1'b0}}, bus.dataB} : product;
  assign step_mcand = (state == IDLE) ? bus.dataA : mcand;

  multu_step #(.WIDTH(WIDTH)) u_step (
    .p      (step_in),
    .mcand  (step_mcand),
    .p_next (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      product <= '0;
      mcand   <= '0;
      count   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_n;
      product <= product_n;
      mcand   <= mcand_n;
      count   <= count_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    product_n = product;
    mcand_n   = mcand;
    count_n   = count;
    hi_n      = hi_q;
    lo_n      = lo_q;
    unique case (state)
      IDLE: begin
        if (bus.Signal == MULTU_CODE) begin
          mcand_n   = bus.dataA;
          product_n = step_out;
          count_n   = 6'd1;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (bus.Signal == MULTU_CODE) begin
          product_n = step_out;
          count_n   = count + 6'd1;
          if (count == LAST) state_n = WAIT_HILO;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_HILO: begin
        if (bus.Signal == HILO_CODE) begin
          hi_n    = product[2*WIDTH-1:WIDTH];
          lo_n    = product[WIDTH-1:0];
          state_n = IDLE;
        end else if (bus.Signal != MULTU_CODE) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state != IDLE);
  assign bus.dataOut = (bus.Signal == MFHI_CODE) ? hi_q :
                       (bus.Signal == MFLO_CODE) ? lo_q : '0;
endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: table vectors, hand-written corner sequences,
// and randomized control streams against a count-and-multiply reference model.
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multu_hilo_if #(.WIDTH(32)) bus ();

  multu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: number of MULTU edges in the current run and the captured operands.
  int unsigned m_n = 0;
  logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_dout(input logic [5:0] code);
    if (code == MFHI_CODE) return m_hi;
    if (code == MFLO_CODE) return m_lo;
    return '0;
  endfunction

  // Drive one control code for one edge, update the model, check all outputs after the edge.
  task automatic apply(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    bus.Signal = code;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    if (code == MULTU_CODE) begin
      if (m_n == 0) begin
        m_a = a;
        m_b = b;
      end
      m_n++;
    end else if (code == HILO_CODE && m_n >= 32) begin
      prod = 64'(m_a) * 64'(m_b);
      m_hi = prod[63:32];
      m_lo = prod[31:0];
      m_n  = 0;
    end else begin
      m_n = 0;
    end
    #1;
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("lo", 64'(bus.lo), 64'(m_lo));
    chk("busy", 64'(bus.busy), 64'(m_n > 0));
    chk("dataOut", 64'(bus.dataOut), 64'(exp_dout(code)));
  endtask

  // Full multiply: start edge, 31 more edges with operands scrambled, extra stretch, HILO.
  task automatic full_mult(input logic [31:0] a, input logic [31:0] b, input int unsigned extra);
    apply(MULTU_CODE, a, b);
    for (int unsigned i = 1; i < 32 + extra; i++) apply(MULTU_CODE, ~a, 32'h0);
    apply(HILO_CODE, '0, '0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int unsigned extra;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [5:0]  codes[6];
    int unsigned len;
    vecs[0] = '{32'd3,          32'd5,          0, 32'h0,        32'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   0, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{32'h00010000,   32'h00010000,   3, 32'h1,        32'h0};
    vecs[3] = '{32'd12,         32'd12,         0, 32'h0,        32'd144};
    vecs[4] = '{32'hFFFFFFFF,   32'd2,          1, 32'h1,        32'hFFFFFFFE};
    vecs[5] = '{32'h80000000,   32'h80000000,   2, 32'h40000000, 32'h0};
    codes   = '{ADD_CODE, SUB_CODE, MFHI_CODE, MFLO_CODE, SLT_CODE, AND_CODE};

    bus.Signal = ADD_CODE;
    bus.dataA  = '0;
    bus.dataB  = '0;
    #12;
    chk("reset_hi", 64'(bus.hi), 64'h0);
    chk("reset_lo", 64'(bus.lo), 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // HILO with no multiply in flight must not write.
    apply(HILO_CODE, 32'd9, 32'd9);

    for (int unsigned v = 0; v < 6; v++) begin
      full_mult(vecs[v].a, vecs[v].b, vecs[v].extra);
      chk("vec_hi", 64'(bus.hi), 64'(vecs[v].eh));
      chk("vec_lo", 64'(bus.lo), 64'(vecs[v].el));
      apply(MFHI_CODE, '0, '0);
      chk("vec_mfhi", 64'(bus.dataOut), 64'(vecs[v].eh));
      apply(MFLO_CODE, '0, '0);
      chk("vec_mflo", 64'(bus.dataOut), 64'(vecs[v].el));
      apply(ADD_CODE, '0, '0);
    end

    // Abort after 10 edges; committed result of vector 5 must survive.
    for (int unsigned i = 0; i < 10; i++) apply(MULTU_CODE, 32'd7, 32'd9);
    apply(ADD_CODE, '0, '0);
    chk("abort_hi", 64'(bus.hi), 64'h40000000);
    chk("abort_busy", 64'(bus.busy), 64'h0);
    // Early HILO also aborts.
    for (int unsigned i = 0; i < 31; i++) apply(MULTU_CODE, 32'd7, 32'd9);
    apply(HILO_CODE, '0, '0);
    chk("early_hilo_lo", 64'(bus.lo), 64'h0);

    // Back-to-back: new multiply on the edge right after the commit.
    full_mult(32'd3, 32'd5, 0);
    full_mult(32'd100, 32'd1000, 0);
    chk("b2b_lo", 64'(bus.lo), 64'd100000);

    // Asynchronous reset between edges in the middle of a run.
    for (int unsigned i = 0; i < 12; i++) apply(MULTU_CODE, 32'd11, 32'd13);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'h0);
    chk("arst_hi", 64'(bus.hi), 64'h0);
    chk("arst_lo", 64'(bus.lo), 64'h0);
    bus.Signal = ADD_CODE;
    @(negedge clk);
    reset = 1'b0;
    m_n = 0; m_hi = '0; m_lo = '0;
    full_mult(32'd6, 32'd7, 0);
    chk("after_rst_lo", 64'(bus.lo), 64'd42);

    // Randomized control streams, checked edge-by-edge by the model.
    for (int unsigned r = 0; r < 40; r++) begin
      len = $urandom_range(1, 36);
      for (int unsigned i = 0; i < len; i++) apply(MULTU_CODE, $urandom, $urandom);
      if ($urandom_range(0, 3) != 0) apply(HILO_CODE, $urandom, $urandom);
      else apply(codes[$urandom_range(0, 5)], $urandom, $urandom);
      apply(codes[$urandom_range(0, 5)], $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
